frame_mem_responder: RTL
========================

FRAME_MEM_RESPONDER -- requirements
Module: frame_mem_responder

Interface
REQ-001 SHALL have clk  in  1  clock, rising-edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have req  in  1  requester wants a memory access this cycle.
REQ-003 SHALL have rd_wr  in  1  0 = read, 1 = write.
REQ-004 SHALL have tem_win  in  1  bank select: 0 = template bank, 1 = window bank.
REQ-005 SHALL have row, col  in  7 each  word address = {row,col}, 14 bits.
REQ-006 SHALL have write_data  in  32  requester write word; read_data  out  32  returned read word.
REQ-007 SHALL have rd_valid  out  1  read_data valid this cycle.
REQ-008 SHALL have set_done  in  1  requester finished frame; set  in  8  requester set count, status only.
REQ-009 SHALL have ready_2_start  out  1  frame loaded, requester may start.
REQ-010 SHALL have host_we  in  1, host_sel  in  1 (0 tmpl, 1 wind), host_addr  in  14, host_wdata  in  32, host_load_done  in  1: host load port.
REQ-011 SHALL have res_we  out  1, res_addr  out  8, res_data  out  32: result write-through to host; err_host  out  1  sticky, host write outside LOAD.

Function
REQ-012 SHALL run FSM LOAD -> ARMED -> SERVE -> FLUSH -> LOAD.
REQ-013 LOAD: host_we=1 writes host_wdata to bank host_sel at host_addr; req ignored; host_load_done=1 -> ARMED next cycle.
REQ-014 ARMED: ready_2_start=1; first cycle with req=1 -> SERVE, and that request SHALL be served.
REQ-015 SERVE: ready_2_start SHALL stay 1 (requester samples it as a level).
REQ-016 Read (req=1, rd_wr=0) in ARMED/SERVE: address and bank registered in cycle N; RAM output registered; rd_valid=1 with the word in cycle N+2.
REQ-017 Reads SHALL be fully pipelined, one accepted per cycle, no backpressure; rd_valid order = request order.
REQ-018 read_data SHALL be 0 whenever rd_valid=0.
REQ-019 Write (req=1, rd_wr=1) in SERVE: res_we=1 next cycle; res_data=write_data; res_addr=result counter.
REQ-020 Result counter 8 bits SHALL increment per write and wrap 255 -> 0; write SHALL NOT touch template/window banks.
REQ-021 set_done=1 in SERVE -> FLUSH; requests in the set_done cycle SHALL be ignored.
REQ-022 FLUSH: in-flight reads (up to 2) SHALL still complete with rd_valid; ready_2_start=0; -> LOAD when pipeline empty.
REQ-023 On LOAD entry, result counter SHALL clear to 0; bank contents SHALL be retained.
REQ-024 host_we=1 outside LOAD SHALL be dropped and set err_host; err_host clears only on reset.
REQ-025 req=1 in LOAD or FLUSH SHALL be ignored, no rd_valid.
REQ-026 host_we and host_load_done in same LOAD cycle: write SHALL complete, then ARMED.
REQ-027 set_done outside SERVE SHALL be ignored.

Reset
REQ-028 rst_n low SHALL force LOAD, ready_2_start=0, rd_valid=0, read_data=0, res_we=0, res_addr=0, res_data=0, err_host=0, result counter=0.
REQ-029 Reset mid-read SHALL discard in-flight reads; no rd_valid after release until a new request.
REQ-030 Bank RAM contents SHALL NOT be reset.

Structure
REQ-031 Shared package SHALL hold FSM state enum, ADDR_W=14, DATA_W=32, RES_W=8, READ_LAT=2.
REQ-032 One sub-module frame_bank_ram (1 write port, 1 registered read port, 16384x32), instanced per bank.

Verification
REQ-033 Host loads tmpl[0x0005]=0xDEADBEEF, load_done; req rd row=0 col=5 tem_win=0 at cycle N -> rd_valid, read_data=0xDEADBEEF at N+2.
REQ-034 Back-to-back reads tmpl{0,1}, wind{0,2} over 3 cycles -> 3 consecutive rd_valid cycles, correct words, request order.
REQ-035 Three writes 0x11,0x22,0x33 in SERVE -> res_we pulses, res_addr 0,1,2; 256 writes -> 256th res_addr=255, 257th res_addr=0.
REQ-036 Read issued in cycle before set_done -> still rd_valid in FLUSH; ready_2_start=0; LOAD entered; next frame res_addr restarts at 0.
REQ-037 host_we in SERVE -> err_host=1, bank word unchanged on later read.
REQ-038 rst_n low one cycle after a read -> no rd_valid; ready_2_start=0; state LOAD.

Source files
------------

// File: rtl/frame_mem_responder_pkg.sv
// Shared types and sizes for the frame memory responder.
// FSM states, read-pipe tag and address helper.
package frame_mem_responder_pkg;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int RES_W    = 8;
  localparam int READ_LAT = 2;
  localparam int ROW_W    = 7;
  localparam int COL_W    = 7;
  localparam int DEPTH    = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ARMED,
    ST_SERVE,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic vld;
    logic sel;
  } rd_tag_t;

  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [ROW_W-1:0] r,
    input logic [COL_W-1:0] c
  );
    return {r, c};
  endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: single write port, registered read port.
// Contents are never reset.
module frame_bank_ram
  import frame_mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // host load writes
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // registered read data
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_mem_responder.sv
// Frame memory responder: host loads banks, requester reads
// them and streams result words back to the host.
module frame_mem_responder
  import frame_mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rd_wr,
  input  logic              tem_win,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  input  logic              set_done,
  input  logic [7:0]        set,
  output logic              ready_2_start,
  input  logic              host_we,
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_load_done,
  output logic              res_we,
  output logic [RES_W-1:0]  res_addr,
  output logic [DATA_W-1:0] res_data,
  output logic              err_host
);

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_ready;
  logic              w_clr_cnt;
  logic              w_pipe_empty;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_host_ok;
  rd_tag_t           r_tag [READ_LAT];
  logic [ADDR_W-1:0] r_raddr;
  logic [RES_W-1:0]  r_cnt;
  logic              r_res_we;
  logic [RES_W-1:0]  r_res_addr;
  logic [DATA_W-1:0] r_res_data;
  logic              r_err;
  logic [DATA_W-1:0] w_tmpl_q;
  logic [DATA_W-1:0] w_wind_q;
  logic              w_unused_set;

  assign w_unused_set = ^set;

  assign w_rd_acc  = w_accept && !rd_wr;
  assign w_wr_acc  = w_accept && rd_wr;
  assign w_host_ok = host_we && (r_state == ST_LOAD);

  // pipeline is empty when no read tag is in flight
  always_comb begin
    w_pipe_empty = 1'b1;
    for (int i = 0; i < READ_LAT; i++) begin
      if (r_tag[i].vld) w_pipe_empty = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_next;
  end

  // next state, request acceptance and ready level
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_ready   = 1'b0;
    w_clr_cnt = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        if (host_load_done) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        w_ready = 1'b1;
        if (req) begin
          w_accept = 1'b1;
          w_next   = ST_SERVE;
        end
      end
      ST_SERVE: begin
        w_ready = 1'b1;
        if (set_done) w_next = ST_FLUSH;
        else          w_accept = req;
      end
      ST_FLUSH: begin
        if (w_pipe_empty) begin
          w_next    = ST_LOAD;
          w_clr_cnt = 1'b1;
        end
      end
      default: w_next = ST_LOAD;
    endcase
  end

  // read tag pipeline: valid and bank per stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{vld: w_rd_acc, sel: tem_win};
      for (int i = 1; i < READ_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // read address register feeding both banks
  always_ff @(posedge clk) begin
    if (w_rd_acc) r_raddr <= word_addr(row, col);
  end

  // result counter: one step per accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (w_clr_cnt) r_cnt <= '0;
    else if (w_wr_acc)  r_cnt <= r_cnt + 1'b1;
  end

  // result write-through to the host
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
    end else begin
      r_res_we <= w_wr_acc;
      if (w_wr_acc) begin
        r_res_addr <= r_cnt;
        r_res_data <= write_data;
      end
    end
  end

  // sticky flag for host writes outside the load phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_err <= 1'b0;
    else if (host_we && r_state != ST_LOAD)   r_err <= 1'b1;
  end

  frame_bank_ram u_tmpl (
    .clk     (clk),
    .i_we    (w_host_ok && !host_sel),
    .i_waddr (host_addr),
    .i_wdata (host_wdata),
    .i_re    (r_tag[0].vld && !r_tag[0].sel),
    .i_raddr (r_raddr),
    .o_rdata (w_tmpl_q)
  );

  frame_bank_ram u_wind (
    .clk     (clk),
    .i_we    (w_host_ok && host_sel),
    .i_waddr (host_addr),
    .i_wdata (host_wdata),
    .i_re    (r_tag[0].vld && r_tag[0].sel),
    .i_raddr (r_raddr),
    .o_rdata (w_wind_q)
  );

  assign rd_valid  = r_tag[READ_LAT-1].vld;
  assign read_data = !r_tag[READ_LAT-1].vld ? '0 :
                     r_tag[READ_LAT-1].sel ? w_wind_q : w_tmpl_q;

  assign ready_2_start = w_ready;
  assign res_we        = r_res_we;
  assign res_addr      = r_res_addr;
  assign res_data      = r_res_data;
  assign err_host      = r_err;

endmodule
